// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W data bits (LSB first), even parity, stop bit.
// Received words go to a single holding register with a valid/ready handshake.
module serial_frame_receiver #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic              serial_in,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_error,
  output logic              framing_error,
  output logic              overrun
);

  localparam int TW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] HALF_M1  = TW'(BIT_CYCLES / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(BIT_CYCLES - 1);
  localparam logic [4:0]    LAST_BIT = 5'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_bit_q, par_bit_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;

  // Even parity: a correct frame has an even number of ones over data and parity bit.
  function automatic logic parity_err(input logic [DATA_W-1:0] word, input logic par);
    return (^word) ^ par;
  endfunction

  // Next-state, bit sampling and holding-register update.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = 1'b0;
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!serial_in) begin
          state_d   = START;
          bit_cnt_d = 5'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          state_d = serial_in ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d   = '0;
          shift_d   = (shift_q >> 1) | (DATA_W'(serial_in) << (DATA_W - 1));
          bit_cnt_d = bit_cnt_q + 5'd1;
          state_d   = (bit_cnt_q == LAST_BIT) ? PARITY : DATA;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (timer_q == FULL_M1) begin
          timer_d   = '0;
          par_bit_d = serial_in;
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          // A full register that is not draining this edge keeps its word; the new frame is lost.
          if (valid_q && !data_ready) begin
            ovr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            perr_d  = parity_err(shift_q, par_bit_q);
            ferr_d  = ~serial_in;
            valid_d = 1'b1;
          end
          state_d = serial_in ? IDLE : BREAK;
        end else begin
          state_d = STOP;
        end
      end
      BREAK: begin
        timer_d = '0;
        state_d = serial_in ? IDLE : BREAK;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset_L.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= 5'd0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: directed frames push expected words,
// a monitor pops and compares whenever a new word appears in the holding register.
module tb_serial_frame_receiver;
  localparam int DATA_W = 8;
  localparam int BC     = 4;
  localparam int STOP_OFS = 1 + BC / 2 + (DATA_W + 2) * BC;

  logic              clock = 1'b0;
  logic              reset_L = 1'b1;
  logic              serial_in = 1'b1;
  logic              data_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_error;
  logic              framing_error;
  logic              overrun;

  serial_frame_receiver #(.DATA_W(DATA_W), .BIT_CYCLES(BC)) dut (
    .clock         (clock),
    .reset_L       (reset_L),
    .serial_in     (serial_in),
    .data_ready    (data_ready),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int ovr_cycles = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Must be called at a negedge; drives start, data (LSB first), parity and stop, BC cycles each.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input bit loads, input logic exp_perr, input logic exp_ferr);
    logic [10:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      serial_in = bits[k];
      if (k == 0 && loads) sb.push_back('{d, exp_perr, exp_ferr, cyc + STOP_OFS});
      repeat (BC) @(negedge clock);
    end
  endtask

  // Monitor: detect loads into the holding register and compare against the scoreboard.
  initial begin
    logic       prev_v;
    logic [7:0] prev_d;
    exp_t       e;
    prev_v = 1'b0;
    prev_d = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      if (data_valid && (!prev_v || data_ready)) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h, no word expected", data_out);
        end else begin
          e = sb.pop_front();
          chk("word_data", int'(data_out), int'(e.data));
          chk("word_parity_error", int'(parity_error), int'(e.perr));
          chk("word_framing_error", int'(framing_error), int'(e.ferr));
          chk("word_load_cycle", cyc, e.at);
        end
      end else if (prev_v && !data_ready && reset_L) begin
        chk("hold_stable_valid", int'(data_valid), 1);
        chk("hold_stable_data", int'(data_out), int'(prev_d));
      end
      if (overrun) ovr_cycles++;
      prev_v = data_valid;
      prev_d = data_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset_L = 1'b0;
    #1;
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_data_valid", int'(data_valid), 0);
    chk("reset_parity_error", int'(parity_error), 0);
    chk("reset_framing_error", int'(framing_error), 0);
    chk("reset_overrun", int'(overrun), 0);
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);

    // Clean frame, consumer always ready: valid for exactly one cycle.
    data_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("a5_valid_one_cycle", int'(data_valid), 0);
    serial_in = 1'b1;
    repeat (4) @(negedge clock);

    // One-cycle low glitch on an idle line.
    serial_in = 1'b0;
    @(negedge clock);
    serial_in = 1'b1;
    repeat (20) @(negedge clock);
    chk("glitch_no_valid", int'(data_valid), 0);

    // Wrong parity bit.
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    serial_in = 1'b1;
    repeat (2) @(negedge clock);

    // Stop bit 0, line held low (break), then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clock);
    chk("break_no_valid", int'(data_valid), 0);
    serial_in = 1'b1;
    repeat (3) @(negedge clock);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b1;
    repeat (2) @(negedge clock);

    // Back-to-back frames with the consumer stalled: second frame is dropped.
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    serial_in = 1'b1;
    @(negedge clock);
    chk("overrun_kept_data", int'(data_out), 8'h11);
    chk("overrun_kept_valid", int'(data_valid), 1);
    chk("overrun_pulse_cycles", ovr_cycles, 1);
    data_ready = 1'b1;
    @(negedge clock);
    chk("ready_clears_valid", int'(data_valid), 0);

    // Reset during data bit 3 of a 0x5A frame (bits LSB first: 0,1,0,1).
    serial_in = 1'b0;
    repeat (BC) @(negedge clock);
    serial_in = 1'b0;
    repeat (BC) @(negedge clock);
    serial_in = 1'b1;
    repeat (BC) @(negedge clock);
    serial_in = 1'b0;
    repeat (BC) @(negedge clock);
    serial_in = 1'b1;
    @(negedge clock);
    #2 reset_L = 1'b0;
    #1;
    chk("midreset_data_out", int'(data_out), 0);
    chk("midreset_data_valid", int'(data_valid), 0);
    chk("midreset_parity_error", int'(parity_error), 0);
    chk("midreset_framing_error", int'(framing_error), 0);
    chk("midreset_overrun", int'(overrun), 0);
    @(negedge clock);
    reset_L = 1'b1;
    repeat (3) @(negedge clock);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b1;

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    chk("overrun_total_cycles", ovr_cycles, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame (range 1..16).
REQ-002 SHALL have parameter BIT_CYCLES, default 4: clock cycles per serial bit (even, >= 2).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port serial_in  input  1  serial line, already synchronized upstream; idles high.
REQ-006 SHALL have port data_ready  input  1  consumer can accept the held word.
REQ-007 SHALL have port data_out  output  DATA_W  received word, LSB received first.
REQ-008 SHALL have port data_valid  output  1  holding register full; data_out and the error flags are valid.
REQ-009 SHALL have port parity_error  output  1  the held word failed the even-parity check.
REQ-010 SHALL have port framing_error  output  1  the held word's stop bit sampled 0.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: a completed frame was dropped.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK; all outputs registered.
REQ-013 In IDLE, serial_in==0 at edge E SHALL move to START with bit-timer cleared; E is the frame reference edge.
REQ-014 Sample edges SHALL be E+BIT_CYCLES/2 (start check) and E+BIT_CYCLES/2+i*BIT_CYCLES for i=1..DATA_W (data, LSB first), i=DATA_W+1 (parity) and i=DATA_W+2 (stop).
REQ-015 A start-check sample of 1 SHALL be treated as a glitch: return to IDLE, no output change.
REQ-016 Parity SHALL be even: parity_error = XOR of the DATA_W data bits and the parity bit.
REQ-017 At the stop sample, the word, parity_error and framing_error (stop==0) SHALL load into the holding register together, and data_valid SHALL be set, provided the register is empty or is being emptied at that same edge.
REQ-018 If the holding register is full and not being emptied at the stop sample, the frame SHALL be dropped: the holding register stays unchanged and overrun is high for exactly the following cycle.
REQ-019 Handshake: data_valid SHALL clear on an edge where data_valid && data_ready and no new word loads; data_out SHALL stay stable while data_valid && !data_ready.
REQ-020 Frames with errors SHALL still be delivered with their flags; the flags SHALL follow data_valid semantics, not be sticky.
REQ-021 After a stop sample of 1, the FSM SHALL return to IDLE; after a stop sample of 0, it SHALL enter BREAK and ignore serial_in==0 until serial_in==1 is sampled, then return to IDLE.
REQ-022 Back-to-back frames SHALL be received when the next start bit falls at or after the edge following the stop sample.
REQ-023 data_ready SHALL have no effect while data_valid==0.

Reset
REQ-024 reset_L==0 SHALL immediately force IDLE, clear the bit-timer and bit counter, and drive data_out=0, data_valid=0, parity_error=0, framing_error=0, overrun=0, independent of clock.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first start bit after release SHALL be received normally.

Verification (DATA_W=8, BIT_CYCLES=4)
REQ-026 Frame 0xA5, parity 0, stop 1, data_ready=1 -> at E+42: data_out=0xA5, data_valid=1 for one cycle, both error flags 0.
REQ-027 serial_in low for 1 cycle, then high -> no data_valid; FSM back in IDLE at E+2.
REQ-028 Frame 0x01 with parity bit 0 -> data_out=0x01, parity_error=1, framing_error=0.
REQ-029 Frame 0x3C with stop bit 0, line held low 8 more cycles -> framing_error=1, no new frame starts until the line goes high, then a 0x55 frame is received correctly.
REQ-030 Frames 0x11 then 0x22 with data_ready=0 -> data_out stays 0x11, overrun pulses once at the second stop; raising data_ready clears data_valid the next edge.
REQ-031 Reset_L pulsed low during data bit 3 of a frame -> all outputs 0 immediately; next frame 0x5A -> data_out=0x5A, no errors.
